crc_enable_sched: RTL and testbench
===================================

// Module: crc_enable_sched
// PURPOSE
//  Shares one CRC engine between NUM_REQ slow-enable requesters (PID check, CRC5, CRC16 paths).
//  - Rising edges of each requester's level enable are queued as pending-pulse counts.
//  - A round-robin arbiter issues single-cycle fast_enable pulses to the CRC engine, tagged with grant_id.
//  - Successive pulses are paced by crc_busy.
//  - Sits between the slow enable synchronizers and the shared CRC datapath.
// PARAMETERS
//  NUM_REQ     3   number of requesters (2..8)
//  CNT_W       4   pending-pulse counter width per requester (saturates at 2**CNT_W-1)
//  TIMEOUT_CYC 64  WAIT-state watchdog limit in cycles (used only with CRC_SCHED_TIMEOUT_EN)
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst          in   1        synchronous, active-high reset
//  slow_enable  in   NUM_REQ  level enables, already synchronized to clk; one bit per requester
//  flush        in   1        1-cycle pulse: discard all pending pulses (EOP / abort)
//  crc_busy     in   1        shared CRC engine busy; high for >=0 cycles after a fast_enable
//  fast_enable  out  1        1-cycle enable pulse to the CRC engine
//  grant_id     out  3        index of requester served by current/last pulse
//  pending      out  NUM_REQ  bit i = requester i has count > 0
//  overflow     out  NUM_REQ  sticky: requester i edge lost to saturation; cleared by rst or flush
//  timeout      out  1        1-cycle pulse on watchdog expiry (0 without CRC_SCHED_TIMEOUT_EN)
// BEHAVIOUR
//  Reset values (rst sampled high at clk edge):
//   - All outputs 0; grant_id=0.
//   - Counters and edge-detect history regs 0; rr pointer = NUM_REQ-1, so requester 0 has priority first.
//  Edge detect:
//   - rise[i] = slow_enable[i] & ~prev[i]; prev registered every cycle.
//   - A level held high produces exactly one rise.
//  Counters:
//   - cnt[i] += rise[i], and -= 1 when requester i is issued that cycle.
//   - Simultaneous rise and issue on the same requester leaves cnt unchanged.
//   - Increment at max saturates and sets overflow[i].
//  FSM, states IDLE, ISSUE, WAIT:
//   - IDLE: if any cnt>0 (registered value), select first i with cnt[i]>0 searching ptr+1, ptr+2, ... modulo NUM_REQ.
//     Load grant_id=i, ptr=i, go ISSUE.
//   - ISSUE: fast_enable=1 for exactly this cycle; cnt[grant_id] decrements; go WAIT.
//   - WAIT: stay while crc_busy=1. When crc_busy=0, go IDLE.
//   - Minimum spacing between pulses is therefore 3 cycles: ISSUE, WAIT, IDLE.
//  Latency: first rise with FSM idle -> fast_enable 3 cycles later:
//   - edge cycle, counter visible, IDLE selects, ISSUE asserts.
//  flush:
//   - Clears all cnt and overflow next cycle.
//   - Rises in the flush cycle are dropped.
//   - In ISSUE, the pulse still completes; in WAIT, waiting continues.
//   - No new grant occurs from flushed counts.
//  rst mid-operation: any state -> IDLE next cycle; an in-flight pulse is not repeated.
//  grant_id holds its value outside ISSUE. Requester indices >= NUM_REQ are never granted.
// CONFIGURATION
//  CRC_SCHED_TIMEOUT_EN defined:
//   - Cycle counter runs in WAIT.
//   - If crc_busy stays 1 for TIMEOUT_CYC consecutive WAIT cycles: pulse timeout for 1 cycle and go IDLE.
//   - The counter clears on leaving WAIT.
//  CRC_SCHED_TIMEOUT_EN undefined:
//   - No watchdog logic; WAIT waits indefinitely.
//   - timeout tied to 0.
// TESTING
//  1. rst 2 cycles; outputs all 0; req0 rises at cycle 5, crc_busy=0
//     -> fast_enable only at cycle 8, grant_id=0.
//  2. req0, req1, req2 rise the same cycle, crc_busy=0
//     -> pulses granted to 0, 1, 2 in order, 3 cycles apart; pending=000 afterward.
//  3. req1 toggles 20 times with FSM blocked (crc_busy=1), CNT_W=4
//     -> cnt saturates at 15, overflow[1]=1; after release exactly 15 pulses with grant_id=1.
//  4. req2 rise in the same cycle req2 is issued with cnt=1
//     -> cnt stays 1; one further pulse to req2 follows.
//  5. flush with cnt={3,2,0} during WAIT
//     -> in-flight wait completes, no further fast_enable, overflow cleared.
//  6. CRC_SCHED_TIMEOUT_EN, crc_busy stuck 1 after a pulse
//     -> timeout pulses 64 cycles into WAIT, FSM returns IDLE, next pending request served.

Source files
------------

// File: rtl/crc_enable_sched_if.sv
// rtl/crc_enable_sched_if.sv - requester/CRC-engine signal bundle for crc_enable_sched
interface crc_enable_sched_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0] slow_enable;
  logic               flush;
  logic               crc_busy;
  logic               fast_enable;
  logic [2:0]         grant_id;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] overflow;
  logic               timeout;

  modport master (
    output slow_enable, flush, crc_busy,
    input  fast_enable, grant_id, pending, overflow, timeout
  );

  modport slave (
    input  slow_enable, flush, crc_busy,
    output fast_enable, grant_id, pending, overflow, timeout
  );
endinterface

// File: rtl/crc_enable_sched.sv
// rtl/crc_enable_sched.sv - round-robin scheduler sharing one CRC engine among slow-enable requesters
// Optional WAIT watchdog is enabled by defining CRC_SCHED_TIMEOUT_EN.
module crc_enable_sched #(
  parameter int NUM_REQ     = 3,
  parameter int CNT_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input logic               clk,
  input logic               rst,
  crc_enable_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] prev_q;
  logic [NUM_REQ-1:0] rise_q, rise_d;
  logic [NUM_REQ-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];
  logic [2:0]         grant_q, grant_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [NUM_REQ-1:0] nz;
  logic [NUM_REQ-1:0] dec;
  logic               sel_found;
  logic [2:0]         sel_idx;
  logic [3:0]         probe;
  logic               issue;
  logic               wd_fire;

  assign issue = (state_q == ISSUE);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      nz[i] = (cnt_q[i] != '0);
    end
  end

  // Search ptr+1, ptr+2, ... wrapping at NUM_REQ; first non-empty counter wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    probe     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      probe = 4'(ptr_q) + 4'(k);
      if (probe >= 4'(NUM_REQ)) begin
        probe = probe - 4'(NUM_REQ);
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!sel_found && (probe == 4'(j)) && nz[j]) begin
          sel_found = 1'b1;
          sel_idx   = 3'(j);
        end
      end
    end
  end

`ifdef CRC_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_d    = '0;
    wd_fire = 1'b0;
    if ((state_q == WAIT) && bus.crc_busy) begin
      if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
        wd_fire = 1'b1;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
  assign wd_fire            = 1'b0;
`endif

  // A flush in IDLE must not turn the about-to-be-cleared counts into a grant.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (sel_found && !bus.flush) begin
          grant_d = sel_idx;
          ptr_d   = sel_idx;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!bus.crc_busy || wd_fire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Edges are registered once before counting; a flush drops both the staged and the new edges.
  always_comb begin
    rise_d = bus.slow_enable & ~prev_q & ~{NUM_REQ{bus.flush}};
    ovf_d  = ovf_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      dec[i]   = issue && (grant_q == 3'(i));
      cnt_d[i] = cnt_q[i];
      if (rise_q[i] && !dec[i]) begin
        if (cnt_q[i] == {CNT_W{1'b1}}) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (dec[i] && !rise_q[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
      if (bus.flush) begin
        cnt_d[i] = '0;
      end
    end
    if (bus.flush) begin
      ovf_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= 3'(NUM_REQ - 1);
      prev_q  <= '0;
      rise_q  <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      prev_q  <= bus.slow_enable;
      rise_q  <= rise_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.fast_enable = issue;
  assign bus.grant_id    = grant_q;
  assign bus.pending     = nz;
  assign bus.overflow    = ovf_q;
  assign bus.timeout     = wd_fire;
endmodule

// File: tb/tb_crc_enable_sched.sv
// tb/tb_crc_enable_sched.sv - directed and randomized self-checking bench for crc_enable_sched
module tb_crc_enable_sched;
  localparam int N    = 3;
  localparam int CW   = 4;
  localparam int TO   = 64;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  crc_enable_sched_if #(.NUM_REQ(N)) bus ();

  crc_enable_sched #(.NUM_REQ(N), .CNT_W(CW), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int p_cyc[$];
  int p_gid[$];
  int t_cyc[$];

  task automatic expect_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int pc(input int k);
    return (k < p_cyc.size()) ? p_cyc[k] : -1;
  endfunction

  function automatic int pg(input int k);
    return (k < p_gid.size()) ? p_gid[k] : -1;
  endfunction

  function automatic int tc(input int k);
    return (k < t_cyc.size()) ? t_cyc[k] : -1;
  endfunction

  // Reference model: per-requester pulse counts plus the time of the next scheduled pulse.
  int         m_cnt [N];
  bit         m_ovf [N];
  int         m_ptr, m_grant, m_pulse_at, m_wlen;
  bit         m_wait, m_valid;
  bit [N-1:0] m_prev, m_late, seen;
  bit         fire, idle, any_cnt, inc_b, dec_b;
  bit         exp_fast, exp_to;
  int         exp_pend, exp_ovf, j;

  always @(negedge clk) begin
    if (m_valid) begin
      exp_fast = (m_pulse_at == cyc);
      exp_pend = 0;
      exp_ovf  = 0;
      for (int i = 0; i < N; i++) begin
        if (m_cnt[i] > 0) exp_pend |= (1 << i);
        if (m_ovf[i])     exp_ovf  |= (1 << i);
      end
`ifdef CRC_SCHED_TIMEOUT_EN
      exp_to = m_wait && bus.crc_busy && (m_wlen + 1 == TO);
`else
      exp_to = 1'b0;
`endif
      expect_eq("fast_enable", int'(bus.fast_enable), int'(exp_fast));
      expect_eq("grant_id",    int'(bus.grant_id),    m_grant);
      expect_eq("pending",     int'(bus.pending),     exp_pend);
      expect_eq("overflow",    int'(bus.overflow),    exp_ovf);
      expect_eq("timeout",     int'(bus.timeout),     int'(exp_to));
    end
    if (bus.fast_enable) begin
      p_cyc.push_back(cyc);
      p_gid.push_back(int'(bus.grant_id));
    end
    if (bus.timeout) t_cyc.push_back(cyc);

    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0;
        m_ovf[i] = 1'b0;
      end
      m_ptr = N - 1; m_grant = 0; m_pulse_at = -1; m_wlen = 0;
      m_wait = 1'b0; m_prev = '0; m_late = '0; m_valid = 1'b1;
    end else if (m_valid) begin
      fire    = (m_pulse_at == cyc);
      idle    = !m_wait && (m_pulse_at < 0);
      any_cnt = 1'b0;
      for (int i = 0; i < N; i++) if (m_cnt[i] > 0) any_cnt = 1'b1;
      if (idle && !bus.flush && any_cnt) begin
        for (int k = 1; k <= N; k++) begin
          j = (m_ptr + k) % N;
          if (m_cnt[j] > 0) begin
            m_grant = j; m_ptr = j; m_pulse_at = cyc + 1;
            break;
          end
        end
      end
      if (fire) begin
        m_wait = 1'b1; m_wlen = 0; m_pulse_at = -1;
      end else if (m_wait) begin
        if (!bus.crc_busy) m_wait = 1'b0;
        else begin
          m_wlen++;
`ifdef CRC_SCHED_TIMEOUT_EN
          if (m_wlen == TO) m_wait = 1'b0;
`endif
        end
      end
      for (int i = 0; i < N; i++) begin
        inc_b = m_late[i];
        dec_b = fire && (m_grant == i);
        if (inc_b && !dec_b) begin
          if (m_cnt[i] == MAXC) m_ovf[i] = 1'b1;
          else m_cnt[i]++;
        end else if (dec_b && !inc_b) begin
          m_cnt[i]--;
        end
        if (bus.flush) begin
          m_cnt[i] = 0;
          m_ovf[i] = 1'b0;
        end
      end
      // An edge seen this cycle becomes countable one cycle later.
      seen   = bus.slow_enable & ~m_prev;
      m_late = bus.flush ? '0 : seen;
      m_prev = bus.slow_enable;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  int s;
  int n_g1;

  initial begin
    rst = 1'b1;
    bus.slow_enable = '0;
    bus.flush       = 1'b0;
    bus.crc_busy    = 1'b0;
    tick(2);
    rst = 1'b0;
    expect_eq("reset fast_enable", int'(bus.fast_enable), 0);
    expect_eq("reset grant_id",    int'(bus.grant_id),    0);
    expect_eq("reset pending",     int'(bus.pending),     0);
    expect_eq("reset overflow",    int'(bus.overflow),    0);
    expect_eq("reset timeout",     int'(bus.timeout),     0);

    // Single requester latency from cycle-5 rise.
    p_cyc.delete(); p_gid.delete();
    tick(3);
    bus.slow_enable = 3'b001;
    tick(7);
    expect_eq("t1 pulse count", p_cyc.size(), 1);
    expect_eq("t1 pulse cycle", pc(0), 8);
    expect_eq("t1 grant",       pg(0), 0);
    bus.slow_enable = '0;
    tick(1);

    // Three simultaneous rises served 0,1,2 three cycles apart.
    do_reset();
    tick(1);
    s = cyc; p_cyc.delete(); p_gid.delete();
    bus.slow_enable = 3'b111;
    tick(14);
    expect_eq("t2 pulse count", p_cyc.size(), 3);
    for (int k = 0; k < 3; k++) begin
      expect_eq("t2 pulse cycle", pc(k), s + 3 + 3 * k);
      expect_eq("t2 grant",       pg(k), k);
    end
    expect_eq("t2 pending", int'(bus.pending), 0);
    bus.slow_enable = '0;

    // Saturation of requester 1 while the engine is held busy.
    do_reset();
    bus.crc_busy = 1'b1;
    tick(1);
    p_cyc.delete(); p_gid.delete();
    for (int k = 0; k < 20; k++) begin
      bus.slow_enable[1] = 1'b1; tick(1);
      bus.slow_enable[1] = 1'b0; tick(1);
    end
    tick(2);
    expect_eq("t3 overflow", int'(bus.overflow), 3'b010);
    expect_eq("t3 pending",  int'(bus.pending),  3'b010);
    bus.crc_busy = 1'b0;
    tick(55);
    n_g1 = 0;
    foreach (p_gid[k]) if (p_gid[k] == 1) n_g1++;
    expect_eq("t3 pulse count", p_cyc.size(), 16);
    expect_eq("t3 grant1 count", n_g1, 16);
    expect_eq("t3 pending after", int'(bus.pending), 0);

    // Flush with counts {3,2,0} while waiting; sticky overflow from above is cleared.
    bus.crc_busy = 1'b1;
    tick(1);
    s = cyc; p_cyc.delete(); p_gid.delete();
    for (int k = 0; k < 4; k++) begin
      bus.slow_enable = (k < 2) ? 3'b011 : 3'b001; tick(1);
      bus.slow_enable = '0; tick(1);
    end
    tick(3);
    expect_eq("t5 pending before flush", int'(bus.pending), 3'b011);
    bus.flush = 1'b1; tick(1); bus.flush = 1'b0;
    expect_eq("t5 pending after flush",  int'(bus.pending),  0);
    expect_eq("t5 overflow after flush", int'(bus.overflow), 0);
    tick(3);
    bus.crc_busy = 1'b0;
    tick(20);
    expect_eq("t5 pulse count", p_cyc.size(), 1);
    expect_eq("t5 pulse cycle", pc(0), s + 3);
    expect_eq("t5 grant",       pg(0), 0);

    // Rise of requester 2 landing on its own issue cycle.
    do_reset();
    tick(1);
    s = cyc; p_cyc.delete(); p_gid.delete();
    bus.slow_enable[2] = 1'b1; tick(1);
    bus.slow_enable[2] = 1'b0; tick(1);
    bus.slow_enable[2] = 1'b1; tick(2);
    expect_eq("t4 pending held", int'(bus.pending), 3'b100);
    bus.slow_enable = '0;
    tick(10);
    expect_eq("t4 pulse count", p_cyc.size(), 2);
    expect_eq("t4 pulse0",      pc(0), s + 3);
    expect_eq("t4 pulse1",      pc(1), s + 6);
    expect_eq("t4 grant1",      pg(1), 2);

    // Stuck busy after a pulse.
    do_reset();
    bus.crc_busy = 1'b1;
    tick(1);
    s = cyc; p_cyc.delete(); p_gid.delete(); t_cyc.delete();
    bus.slow_enable = 3'b011; tick(1);
    bus.slow_enable = '0;
    tick(80);
`ifdef CRC_SCHED_TIMEOUT_EN
    expect_eq("t6 timeout cycle", tc(0), s + 67);
    expect_eq("t6 next pulse",    pc(1), s + 69);
    expect_eq("t6 next grant",    pg(1), 1);
`else
    expect_eq("t6 timeout count", t_cyc.size(), 0);
    expect_eq("t6 pulse count",   p_cyc.size(), 1);
    expect_eq("t6 pending",       int'(bus.pending), 3'b010);
`endif
    bus.crc_busy = 1'b0;
    tick(10);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(3) == 0) bus.slow_enable[b] = ~bus.slow_enable[b];
      end
      bus.flush = ($urandom_range(39) == 0);
      if ((c % 1000) >= 900 && (c % 1000) < 990) bus.crc_busy = 1'b1;
      else bus.crc_busy = ($urandom_range(2) == 0);
      rst = ($urandom_range(699) == 0);
      tick(1);
    end
    rst = 1'b0; bus.flush = 1'b0; bus.crc_busy = 1'b0; bus.slow_enable = '0;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
